// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Optional saturation support is enabled with `define ADDSUB_SATURATE_EN.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Per-stage control payload; carry is the carry leaving the segment just resolved.
  typedef struct packed {
    logic valid;
    logic skip;
    logic carry;
    logic ovf;
`ifdef ADDSUB_SATURATE_EN
    logic sat;
`endif
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_addsub_if.sv
// Handshake and data bundle of the pipelined add/subtract unit.
// The sat request line exists only when ADDSUB_SATURATE_EN is defined.
interface pipe_addsub_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             addOrSub;
  logic             skip;
`ifdef ADDSUB_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, data_operandA, data_operandB, addOrSub, skip,
`ifdef ADDSUB_SATURATE_EN
    sat,
`endif
    out_ready,
    input  in_ready, out_valid, data_result, overflow, carry_out
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, addOrSub, skip,
`ifdef ADDSUB_SATURATE_EN
    sat,
`endif
    out_ready,
    output in_ready, out_valid, data_result, overflow, carry_out
  );

endinterface

// File: rtl/addsub_segment.sv
// Combinational SEG-bit adder slice; also reports the carry into its top bit
// so the final slice can derive signed overflow.
module addsub_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  end

  // Carry into the top bit recovered from the top-bit sum identity.
  assign cmsb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement add/subtract: one carry segment per stage, valid/ready
// with full backpressure. Define ADDSUB_SATURATE_EN to add the sat clamp option.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic           clock,
  input logic           reset_n,
  pipe_addsub_if.slave  bus
);

  localparam int SEG = seg_width(WIDTH, STAGES);

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_in;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  stage_ctrl_t      ctrl_q[STAGES];

  always_comb begin
    b_eff = '0;
    c_in  = 1'b0;
    if (!bus.skip) begin
      b_eff = (bus.addOrSub == OP_SUB) ? ~bus.data_operandB : bus.data_operandB;
      c_in  = (bus.addOrSub == OP_SUB);
    end
  end

  assign stall         = ctrl_q[STAGES-1].valid & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = ctrl_q[STAGES-1].valid;
  assign bus.data_result = sum_q[STAGES-1];
  assign bus.overflow  = ctrl_q[STAGES-1].ovf;
  assign bus.carry_out = ctrl_q[STAGES-1].carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_next;
    stage_ctrl_t      ctrl_in;
    stage_ctrl_t      ctrl_next;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic             seg_cmsb;

    if (k == 0) begin : g_head
      always_comb begin
        a_in          = bus.data_operandA;
        b_in          = b_eff;
        sum_in        = '0;
        ctrl_in       = '0;
        ctrl_in.valid = bus.in_valid;
        ctrl_in.skip  = bus.skip;
        ctrl_in.carry = c_in;
`ifdef ADDSUB_SATURATE_EN
        ctrl_in.sat   = bus.sat;
`endif
      end
    end else begin : g_body
      always_comb begin
        a_in    = a_q[k-1];
        b_in    = b_q[k-1];
        sum_in  = sum_q[k-1];
        ctrl_in = ctrl_q[k-1];
      end
    end

    addsub_segment #(.SEG(SEG)) u_seg (
      .a    (a_in[k*SEG +: SEG]),
      .b    (b_in[k*SEG +: SEG]),
      .cin  (ctrl_in.carry),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    // Only the last stage's ovf is meaningful; earlier stages carry it along unused.
    always_comb begin
      sum_next                 = sum_in;
      sum_next[k*SEG +: SEG]   = seg_sum;
      ctrl_next                = ctrl_in;
      ctrl_next.carry          = seg_cout & ~ctrl_in.skip;
      ctrl_next.ovf            = (seg_cmsb ^ seg_cout) & ~ctrl_in.skip;
`ifdef ADDSUB_SATURATE_EN
      if ((k == STAGES-1) && ctrl_in.sat && ctrl_next.ovf) begin
        sum_next = a_in[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
`endif
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        ctrl_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        sum_q[k]  <= '0;
      end else if (!stall) begin
        ctrl_q[k] <= ctrl_next;
        a_q[k]    <= a_in;
        b_q[k]    <= b_in;
        sum_q[k]  <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed corner cases plus randomized traffic
// against a slot-level reference model. Honours ADDSUB_SATURATE_EN when defined.
module tb_pipe_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic        o;
    logic        c;
  } exp_t;

  exp_t slot [STAGES];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference result from plain signed/unsigned arithmetic.
  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, input logic skp, input logic sat);
    exp_t   e;
    longint sa, sb, ua, ub, full;
    e.v = 1'b1;
    if (skp) begin
      e.r = a;
      e.o = 1'b0;
      e.c = 1'b0;
      return e;
    end
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'({32'b0, a});
    ub   = longint'({32'b0, b});
    full = sub ? (sa - sb) : (sa + sb);
    e.r  = full[31:0];
    e.o  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    e.c  = sub ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
    if (sat && e.o) e.r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return e;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < STAGES; i++) begin
      slot[i].v = 1'b0;
      slot[i].r = '0;
      slot[i].o = 1'b0;
      slot[i].c = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic skp, input logic sat, input logic rdy);
    bus.in_valid      = v;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.addOrSub      = sub;
    bus.skip          = skp;
    bus.out_ready     = rdy;
`ifdef ADDSUB_SATURATE_EN
    bus.sat           = sat;
`else
    if (sat) $display("[TB] note: sat requested but saturation is not built in");
`endif
  endtask

  // Check outputs mid-cycle, then advance model and DUT by one clock.
  task automatic step(input string tag, output logic accepted);
    exp_t e, ne;
    logic stall_e, sat_bit;
    #1;
    e = slot[STAGES-1];
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e.v));
    stall_e = e.v && !bus.out_ready;
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!stall_e));
    if (e.v) begin
      checkOutput({tag, ".result"},    bus.data_result,       e.r);
      checkOutput({tag, ".overflow"},  32'(bus.overflow),     32'(e.o));
      checkOutput({tag, ".carry_out"}, 32'(bus.carry_out),    32'(e.c));
    end
`ifdef ADDSUB_SATURATE_EN
    sat_bit = bus.sat;
`else
    sat_bit = 1'b0;
`endif
    accepted = reset_n && bus.in_valid && !stall_e;
    ne   = refModel(bus.data_operandA, bus.data_operandB, bus.addOrSub, bus.skip, sat_bit);
    ne.v = accepted;
    @(posedge clock);
    if (!reset_n) begin
      clearModel();
    end else if (!stall_e) begin
      for (int i = STAGES-1; i > 0; i--) slot[i] = slot[i-1];
      slot[0] = ne;
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        skp;
  } vec_t;

  initial begin
    vec_t dir [7];
    logic acc;
    int   issued;

    dir[0] = '{32'd5,         32'd3,         1'b0, 1'b0};
    dir[1] = '{32'h0000_FFFF, 32'd1,         1'b0, 1'b0};
    dir[2] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0};
    dir[3] = '{32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0};
    dir[4] = '{32'h8000_0000, 32'd1,         1'b1, 1'b0};
    dir[5] = '{32'd10,        32'd3,         1'b1, 1'b0};
    dir[6] = '{32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b1};

    clearModel();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    clearModel();

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("reset", acc);

    // Single 5+3, then drain to observe exact latency.
    applyStimulus(1'b1, dir[0].a, dir[0].b, dir[0].sub, dir[0].skp, 1'b0, 1'b1);
    step("lat", acc);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (STAGES + 1) step("lat", acc);

    for (int i = 1; i < 7; i++) begin
      applyStimulus(1'b1, dir[i].a, dir[i].b, dir[i].sub, dir[i].skp, 1'b0, 1'b1);
      step($sformatf("dir%0d", i), acc);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (STAGES + 1) step("dir_drain", acc);

`ifdef ADDSUB_SATURATE_EN
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("sat", acc);
    applyStimulus(1'b1, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    step("sat", acc);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (STAGES + 1) step("sat_drain", acc);
`endif

    // Eight back-to-back ops with the consumer stalled during cycles 5..9.
    issued = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(issued < 8, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                    1'b0, 1'b0, !(c >= 5 && c <= 9));
      step("stall", acc);
      if (acc) issued++;
    end
    checkOutput("stall.issued", 32'(issued), 32'd8);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'b0, 1'b0, 1'b1);
      step("flight", acc);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    step("midreset", acc);
    reset_n = 1'b1;
    repeat (STAGES + 2) step("postreset", acc);

    for (int c = 0; c < 1500; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, randOperand(), randOperand(),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      step("rand", acc);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (STAGES + 1) step("rand_drain", acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined two's-complement add/subtract unit for the multdiv datapath and the ALU.
- Splits a WIDTH-bit carry chain into STAGES equal segments and resolves one segment per cycle, so the adder no longer limits clock frequency.
- Valid/ready handshakes on input and output, with full backpressure.
- Keeps the existing add/sub/skip operand semantics and adds carry-out and optional saturation.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth = number of carry segments (1..WIDTH); SEG = WIDTH/STAGES.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts operation this cycle
- data_operandA  in  WIDTH  operand A
- data_operandB  in  WIDTH  operand B
- addOrSub  in  1  0 = A+B, 1 = A-B
- skip  in  1  1 = treat B as zero (pass-through of A)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- data_result  out  WIDTH  sum/difference
- overflow  out  1  signed overflow
- carry_out  out  1  carry out of MSB (unsigned carry / not-borrow)

Behaviour:
- Reset: reset_n sampled low on a clock edge clears every stage-valid bit, out_valid, data_result, overflow and carry_out to 0. Data registers may also be cleared.
  - Reset mid-operation discards all in-flight operations; nothing is emitted afterwards.
  - in_ready is 1 in the first cycle after reset.
- Effective operand:
  - Beff = skip ? 0 : (addOrSub ? ~B : B)
  - cin = skip ? 0 : addOrSub
  - skip therefore always yields A exactly, with overflow=0. The sub+skip case is defined as A, not A+1.
- Pipeline:
  - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and Beff with the carry registered from stage k-1; stage 0 uses cin.
  - Higher operand slices travel in skew registers.
  - Completed low slices travel in deskew registers, so the full result emerges aligned.
- Latency: exactly STAGES cycles from handshake (in_valid & in_ready) to out_valid, when there is no backpressure. Throughput is one operation per cycle.
- Stall and handshake:
  - stall = out_valid & ~out_ready. While stall is high, the whole pipeline holds and in_ready = 0.
  - Otherwise in_ready = 1 and the pipeline advances; bubbles propagate as valid=0.
  - out_valid, data_result, overflow and carry_out stay stable while stalled.
  - Order is preserved; nothing is lost or duplicated.
- Flags, computed in the final stage:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
  - Both flags are forced to 0 when skip=1.
- STAGES=1: a single registered full-width adder with latency 1.
- Simultaneous in_valid and out_ready at a full pipe: the output retires and the new operation enters in the same cycle.
- data_result while out_valid=0 is don't-care; the bench must not check it.

Optional Feature:
- Macro ADDSUB_SATURATE_EN, plus an input port sat (1 bit) that exists only when the macro is defined.
- Defined:
  - With sat=1, carried down the pipe with its operation, an overflowing result is clamped: to 2^(WIDTH-1)-1 when A is non-negative, otherwise to -2^(WIDTH-1).
  - overflow is still reported as 1.
  - carry_out is unaffected.
- Undefined:
  - No sat port; results always wrap modulo 2^WIDTH.
  - No clamp logic is generated.

Decomposition:
- Package addsub_pkg:
  - op-select constants OP_ADD=1'b0, OP_SUB=1'b1
  - localparam function for SEG
  - stage-payload struct typedef: A/B slices, cin, skip, valid, (sat)
- Sub-module addsub_segment:
  - combinational SEG-bit adder slice with cin
  - outputs sum, cout, and carry into its top bit (for overflow)
  - instantiated STAGES times via generate.

Test Plan (WIDTH=32, STAGES=4):
- 5 + 3, out_ready=1 → 0x00000008 after exactly 4 cycles, overflow=0, carry_out=0.
- 0x0000FFFF + 1 → 0x00010000 (carry crosses segment boundary); 0xFFFFFFFF + 1 → 0x00000000, carry_out=1, overflow=0.
- 0x7FFFFFFF + 1 → 0x80000000 overflow=1; sub 0x80000000 − 1 → 0x7FFFFFFF overflow=1; sub 10 − 3 → 7, carry_out=1.
- skip=1, addOrSub=1, A=0x00001234, B=0xFFFFFFFF → 0x00001234, overflow=0, carry_out=0.
- 8 back-to-back ops with out_ready=0 for cycles 5–9 → in_ready=0 while stalled, held outputs stable, all 8 results in order, none lost.
- Reset_n low for one cycle with 3 ops in flight → out_valid=0 next cycle, no stale result emitted. With ADDSUB_SATURATE_EN and sat=1: 0x7FFFFFFF+1 → 0x7FFFFFFF, overflow=1.
